fetch_sequencer: RTL and testbench

Instruction-fetch controller for the single-cycle core's byte-addressed, combinational-read `instruction_memory`. It owns the 64-bit program counter and drives `inst_address`. It registers each returned 32-bit word, with its PC, into a one-entry output stage that uses a valid/ready handshake toward decode. It accepts branch redirects from execute and stops cleanly when the PC leaves the populated program image.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_out_stage.sv | 34 +++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Optional misaligned-redirect trap is enabled with FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

   localparam int unsigned PC_W       = 64;
   localparam int unsigned INST_W     = 32;
   localparam int unsigned INST_BYTES = 4;
   localparam int unsigned SUM_W      = PC_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   // Carry-extended bounds check so a PC near 2^64 never appears to fit.
   function automatic logic fits_image(input logic [PC_W-1:0] pc,
                                       input logic [PC_W-1:0] mem_bytes);
      logic [SUM_W-1:0] w_end;
      w_end = {1'b0, pc} + SUM_W'(INST_BYTES);
      return (w_end <= {1'b0, mem_bytes});
   endfunction

endpackage

// File: rtl/fetch_out_stage.sv
// One-entry valid/ready holding register between fetch and decode.
// Flush wins over capture; an accepted entry with no refill drains the stage.
module fetch_out_stage
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_capture,
   input  logic              i_flush,
   input  logic              i_ready,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [INST_W-1:0] i_instr,
   output logic              o_valid,
   output logic [PC_W-1:0]   o_pc,
   output logic [INST_W-1:0] o_instr
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_valid <= 1'b0;
         o_pc    <= '0;
         o_instr <= '0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (i_capture) begin
         o_valid <= 1'b1;
         o_pc    <= i_pc;
         o_instr <= i_instr;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, sequences fetches into a one-entry output stage,
// takes execute redirects and halts off the image. FETCH_ALIGN_CHECK_EN adds a misalign trap.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [PC_W-1:0] MEM_BYTES = PC_W'(88)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [PC_W-1:0]   inst_address,
   input  logic [INST_W-1:0] instruction,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_instr,
   output logic              halted
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic              misalign_fault
`endif
);

   fetch_state_t    r_state;
   logic [PC_W-1:0] r_pc;
   logic            r_halted;
`ifdef FETCH_ALIGN_CHECK_EN
   logic            r_fault;
   logic            w_misalign;
`endif

   logic            w_active;
   logic            w_redir;
   logic            w_can_cap;
   logic            w_fits;
   logic            w_fetch;
   logic            w_capture;
   logic            w_flush;
   logic [PC_W-1:0] w_redirect_pc;

   assign w_active  = (r_state == RUN) || (r_state == HALT);
   assign w_redir   = redirect_valid && w_active;
   assign w_can_cap = !out_valid || out_ready;
   assign w_fits    = fits_image(r_pc, MEM_BYTES);
   assign w_fetch   = (r_state == RUN) && !w_redir && w_can_cap;
   assign w_capture = w_fetch && w_fits;
   assign w_flush   = w_redir || (w_fetch && !w_fits);

`ifdef FETCH_ALIGN_CHECK_EN
   assign w_misalign    = (redirect_pc[1:0] != 2'b00);
   assign w_redirect_pc = redirect_pc;
`else
   // Without the trap, targets are silently word-aligned.
   assign w_redirect_pc = redirect_pc & ~PC_W'(INST_BYTES - 1);
`endif

   // State, PC and status flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_pc     <= RESET_PC;
         r_halted <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         r_fault  <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) r_state <= RUN;
            end
            RUN, HALT: begin
               if (w_redir) begin
`ifdef FETCH_ALIGN_CHECK_EN
                  if (w_misalign) begin
                     r_state  <= FAULT;
                     r_halted <= 1'b0;
                     r_fault  <= 1'b1;
                  end else
`endif
                  begin
                     r_pc     <= w_redirect_pc;
                     r_state  <= RUN;
                     r_halted <= 1'b0;
                  end
               end else if (w_fetch) begin
                  if (w_fits) begin
                     r_pc <= r_pc + PC_W'(INST_BYTES);
                  end else begin
                     r_state  <= HALT;
                     r_halted <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= r_state;
            end
         endcase
      end
   end

   assign inst_address = r_pc;
   assign halted       = r_halted;
`ifdef FETCH_ALIGN_CHECK_EN
   assign misalign_fault = r_fault;
`endif

   fetch_out_stage u_out_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_capture (w_capture),
      .i_flush   (w_flush),
      .i_ready   (out_ready),
      .i_pc      (r_pc),
      .i_instr   (instruction),
      .o_valid   (out_valid),
      .o_pc      (out_pc),
      .o_instr   (out_instr)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: program-image memory, behavioural model with per-cycle
// compare, and directed scenarios with literal expectations (FETCH_ALIGN_CHECK_EN aware).
module tb_fetch_sequencer;

   localparam logic [63:0] RESET_PC  = 64'h0;
   localparam logic [63:0] MEM_BYTES = 64'd88;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [63:0] inst_address;
   logic [31:0] instruction;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign_fault;
`endif

   always #5 clk = ~clk;

   fetch_sequencer #(.RESET_PC(RESET_PC), .MEM_BYTES(MEM_BYTES)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .inst_address   (inst_address),
      .instruction    (instruction),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .halted         (halted)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .misalign_fault (misalign_fault)
`endif
   );

   // Program image: 22 words, 88 bytes.
   logic [31:0] mem [0:21];
   initial begin
      mem[0]  = 32'h00000913; mem[1]  = 32'h00000433; mem[2]  = 32'h04b40863;
      mem[3]  = 32'h00800eb3; mem[4]  = 32'h000409b3; mem[5]  = 32'h00498993;
      mem[6]  = 32'h0009a703; mem[7]  = 32'h00870733; mem[8]  = 32'h02be8663;
      mem[9]  = 32'h00e92023; mem[10] = 32'h00440413; mem[11] = 32'h001e8e93;
      for (int i = 12; i < 21; i++) mem[i] = 32'h00000013;
      mem[21] = 32'hfa000ae3;
   end

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a <= 64'd84 && a[1:0] == 2'b00) return mem[a[6:2]];
      return 32'hdeadbeef;
   endfunction

   always_comb instruction = mem_word(inst_address);

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: spec rules applied to the sampled inputs each rising edge.
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
   int          m_mode;
   logic [63:0] m_pc, m_opc;
   logic [31:0] m_instr;
   logic        m_valid, m_fault;
   logic        m_init = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_mode  <= M_IDLE;
         m_pc    <= RESET_PC;
         m_valid <= 1'b0;
         m_opc   <= 64'h0;
         m_instr <= 32'h0;
         m_fault <= 1'b0;
         m_init  <= 1'b1;
      end else if (m_mode == M_IDLE) begin
         if (start) m_mode <= M_RUN;
      end else if (m_mode != M_FAULT && redirect_valid) begin
         m_valid <= 1'b0;
         if (ALIGN_CHECK && redirect_pc[1:0] != 2'b00) begin
            m_mode  <= M_FAULT;
            m_fault <= 1'b1;
         end else begin
            m_pc   <= {redirect_pc[63:2], 2'b00};
            m_mode <= M_RUN;
         end
      end else if (m_mode == M_RUN && (!m_valid || out_ready)) begin
         if (m_pc <= MEM_BYTES - 64'd4) begin
            m_opc   <= m_pc;
            m_instr <= mem_word(m_pc);
            m_valid <= 1'b1;
            m_pc    <= m_pc + 64'd4;
         end else begin
            m_mode  <= M_HALT;
            m_valid <= 1'b0;
         end
      end
   end

   logic seen14 = 1'b0;

   // Per-cycle compare against the model, on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_init) begin
            chk("m.out_valid", 64'(out_valid), 64'(m_valid));
            chk("m.inst_address", inst_address, m_pc);
            chk("m.halted", 64'(halted), 64'(m_mode == M_HALT));
            if (m_valid) begin
               chk("m.out_pc", out_pc, m_opc);
               chk("m.out_instr", 64'(out_instr), 64'(m_instr));
            end
`ifdef FETCH_ALIGN_CHECK_EN
            chk("m.misalign_fault", 64'(misalign_fault), 64'(m_fault));
`endif
            if (out_valid && out_pc == 64'h14) seen14 = 1'b1;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic expect_entry(input string name, input logic [63:0] pc, input logic [31:0] ins);
      chk({name, ".valid"}, 64'(out_valid), 64'd1);
      chk({name, ".pc"}, out_pc, pc);
      chk({name, ".instr"}, 64'(out_instr), 64'(ins));
   endtask

   initial begin
      bit found;
      rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.inst_address", inst_address, 64'h0);
      chk("rst.halted", 64'(halted), 64'd0);
      chk("rst.out_pc", out_pc, 64'h0);
      chk("rst.out_instr", 64'(out_instr), 64'h0);

      // Sequential fetch with decode always ready.
      rst_n = 1'b1; out_ready = 1'b1;
      tick();
      chk("idle.out_valid", 64'(out_valid), 64'd0);
      start = 1'b1; tick(); start = 1'b0;
      chk("run1.out_valid", 64'(out_valid), 64'd0);
      tick(); expect_entry("seq0", 64'h0, 32'h00000913);
      tick(); expect_entry("seq1", 64'h4, 32'h00000433);
      tick(); expect_entry("seq2", 64'h8, 32'h04b40863);
      tick(); expect_entry("seq3", 64'hC, 32'h00800eb3);

      // Backpressure holds the entry and the PC.
      out_ready = 1'b0;
      repeat (3) begin
         tick();
         chk("bp.out_instr", 64'(out_instr), 64'h00800eb3);
         chk("bp.inst_address", inst_address, 64'h10);
      end
      out_ready = 1'b1;
      tick(); expect_entry("bp.release", 64'h10, 32'h000409b3);

      // Redirect while holding 0x10: one bubble, 0x14 skipped.
      redirect_valid = 1'b1; redirect_pc = 64'h20;
      tick(); redirect_valid = 1'b0;
      chk("redir.bubble", 64'(out_valid), 64'd0);
      tick(); expect_entry("redir.target", 64'h20, 32'h02be8663);
      chk("redir.no14", 64'(seen14), 64'd0);

      // Run off the end of the image.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (out_valid && out_pc == 64'h54) found = 1'b1;
         else tick();
      end
      chk("end.found54", 64'(found), 64'd1);
      chk("end.instr54", 64'(out_instr), 64'hfa000ae3);
      tick();
      chk("end.halted", 64'(halted), 64'd1);
      chk("end.out_valid", 64'(out_valid), 64'd0);
      tick();
      chk("end.halted_hold", 64'(halted), 64'd1);

      // Redirect out of HALT.
      redirect_valid = 1'b1; redirect_pc = 64'h8;
      tick(); redirect_valid = 1'b0;
      chk("resume.halted", 64'(halted), 64'd0);
      chk("resume.bubble", 64'(out_valid), 64'd0);
      tick(); expect_entry("resume", 64'h8, 32'h04b40863);

      // Misaligned redirect target.
      redirect_valid = 1'b1; redirect_pc = 64'h22;
      tick(); redirect_valid = 1'b0;
      chk("mis.bubble", 64'(out_valid), 64'd0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis.fault", 64'(misalign_fault), 64'd1);
      repeat (4) begin
         tick();
         chk("mis.no_valid", 64'(out_valid), 64'd0);
      end
`else
      tick(); expect_entry("mis.aligned", 64'h20, 32'h02be8663);
`endif

      // Reset together with redirect, mid-run.
      rst_n = 1'b0; tick();
      rst_n = 1'b1; start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h40;
      tick();
      chk("rr.out_valid", 64'(out_valid), 64'd0);
      chk("rr.inst_address", inst_address, RESET_PC);
      chk("rr.halted", 64'(halted), 64'd0);
      rst_n = 1'b1;
      tick(); redirect_valid = 1'b0;
      repeat (3) begin
         tick();
         chk("rr.idle_valid", 64'(out_valid), 64'd0);
         chk("rr.idle_addr", inst_address, RESET_PC);
      end
      start = 1'b1; tick(); start = 1'b0;
      tick(); expect_entry("rr.restart", 64'h0, 32'h00000913);

      // Redirect near 2^64: the carried sum must fail the bounds check.
      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      tick(); redirect_valid = 1'b0;
      chk("wrap.addr", inst_address, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      chk("wrap.halted", 64'(halted), 64'd1);
      chk("wrap.out_valid", 64'(out_valid), 64'd0);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
